// File: rtl/hssl_link_pkg.sv
// hssl_link_pkg: shared state encoding, widths and helpers for the HSSL link manager.
package hssl_link_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_TX_RST  = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_RX_RST  = 3'd3,
    ST_RX_WAIT = 3'd4,
    ST_ALIGN   = 3'd5,
    ST_UP      = 3'd6
  } link_state_e;

  // Saturating increment for the status counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic inc);
    return (inc && (value != '1)) ? value + CNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/hssl_link_channel_fsm.sv
// hssl_link_channel_fsm: bring-up and supervision FSM for one transceiver channel.
// Optional statistics counters are built only when HSSL_LINK_STATS_EN is defined.
module hssl_link_channel_fsm
  import hssl_link_pkg::*;
#(
  parameter int unsigned RESET_PULSE     = 16,
  parameter int unsigned RESET_TIMEOUT   = 65535,
  parameter int unsigned SYNC_GOOD_COUNT = 64,
  parameter int unsigned ERR_WINDOW      = 1024,
  parameter int unsigned ERR_THRESHOLD   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tx_reset_done,
  input  logic               rx_reset_done,
  input  logic               rx_commadet,
  input  logic               rx_error,
  output logic               tx_reset_datapath,
  output logic               rx_reset_datapath,
  output logic               link_up,
  output logic [STATE_W-1:0] link_state,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   resync_count
);

  localparam int unsigned MAX_TMR = (RESET_TIMEOUT > RESET_PULSE) ? RESET_TIMEOUT : RESET_PULSE;
  localparam int unsigned TMR_W   = $clog2(MAX_TMR + 1);
  localparam int unsigned GOOD_W  = $clog2(SYNC_GOOD_COUNT + 1);
  localparam int unsigned WIN_W   = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int unsigned WERR_W  = $clog2(ERR_THRESHOLD + 1);

  link_state_e       state;
  link_state_e       state_next;
  logic [TMR_W-1:0]  timer;
  logic [GOOD_W-1:0] good;
  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] win_err;

  logic              pulse_done_c;
  logic              timeout_c;
  logic              sync_c;
  logic              win_wrap_c;
  logic [WERR_W:0]   win_err_sum_c;
  logic              thresh_c;

  // Phase timer, comma counter and error-window decode
  always_comb begin
    pulse_done_c  = (timer == TMR_W'(RESET_PULSE - 1));
    timeout_c     = (timer == TMR_W'(RESET_TIMEOUT - 1));
    sync_c        = (good == GOOD_W'(SYNC_GOOD_COUNT - 1)) && rx_commadet && !rx_error;
    win_wrap_c    = (win_cnt == WIN_W'(ERR_WINDOW - 1));
    // An error on the wrap cycle is the first error of the new window
    win_err_sum_c = (win_wrap_c ? '0 : {1'b0, win_err}) + (WERR_W+1)'(rx_error);
    thresh_c      = (win_err_sum_c >= (WERR_W+1)'(ERR_THRESHOLD));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a dropped enable overrides every other condition
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable) state_next = ST_TX_RST;
      ST_TX_RST:  if (pulse_done_c) state_next = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (tx_reset_done)  state_next = ST_RX_RST;
        else if (timeout_c) state_next = ST_TX_RST;
      end
      ST_RX_RST:  if (pulse_done_c) state_next = ST_RX_WAIT;
      ST_RX_WAIT: begin
        if (rx_reset_done)  state_next = ST_ALIGN;
        else if (timeout_c) state_next = ST_RX_RST;
      end
      ST_ALIGN: begin
        if (sync_c)         state_next = ST_UP;
        else if (timeout_c) state_next = ST_RX_RST;
      end
      ST_UP: begin
        if (!tx_reset_done)      state_next = ST_TX_RST;
        else if (!rx_reset_done) state_next = ST_RX_WAIT;
        else if (thresh_c)       state_next = ST_RX_RST;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  // Output decode from the registered state
  always_comb begin
    tx_reset_datapath = 1'b0;
    rx_reset_datapath = 1'b0;
    link_up           = 1'b0;
    case (state)
      ST_IDLE, ST_TX_RST: begin
        tx_reset_datapath = 1'b1;
        rx_reset_datapath = 1'b1;
      end
      ST_TX_WAIT, ST_RX_RST: rx_reset_datapath = 1'b1;
      ST_UP:                 link_up = 1'b1;
      default: ;
    endcase
  end

  assign link_state = state;

  // Per-state counters, all cleared on any state entry
  always_ff @(posedge clk) begin
    if (reset || (state_next != state)) begin
      timer   <= '0;
      good    <= '0;
      win_cnt <= '0;
      win_err <= '0;
    end else begin
      if (timer != '1) timer <= timer + TMR_W'(1);
      if (state == ST_ALIGN)
        good <= rx_error ? '0 : (rx_commadet ? good + GOOD_W'(1) : good);
      if (state == ST_UP) begin
        win_cnt <= win_wrap_c ? '0 : win_cnt + WIN_W'(1);
        win_err <= win_err_sum_c[WERR_W-1:0];
      end
    end
  end

`ifdef HSSL_LINK_STATS_EN
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] resync_q;
  logic             resync_ev_c;

  // Every retry edge moves backwards to a non-IDLE state; forward progress and disable do not
  assign resync_ev_c = (state_next != ST_IDLE) && (state_next < state);

  // Saturating statistics, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= '0;
      resync_q <= '0;
    end else begin
      err_q    <= sat_inc(err_q, (state == ST_UP) && rx_error);
      resync_q <= sat_inc(resync_q, resync_ev_c);
    end
  end

  assign err_count    = err_q;
  assign resync_count = resync_q;
`else
  assign err_count    = '0;
  assign resync_count = '0;
`endif

endmodule

// File: rtl/hssl_link_manager.sv
// hssl_link_manager: NUM_CHANNELS independent HSSL link bring-up controllers.
// Define HSSL_LINK_STATS_EN to build the per-channel error/resync counters.
module hssl_link_manager
  import hssl_link_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 1,
  parameter int unsigned RESET_PULSE     = 16,
  parameter int unsigned RESET_TIMEOUT   = 65535,
  parameter int unsigned SYNC_GOOD_COUNT = 64,
  parameter int unsigned ERR_WINDOW      = 1024,
  parameter int unsigned ERR_THRESHOLD   = 4
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic [NUM_CHANNELS-1:0]           enable_in,
  input  logic [NUM_CHANNELS-1:0]           tx_reset_done_in,
  input  logic [NUM_CHANNELS-1:0]           rx_reset_done_in,
  input  logic [NUM_CHANNELS-1:0]           rx_commadet_in,
  input  logic [NUM_CHANNELS-1:0]           rx_error_in,
  output logic [NUM_CHANNELS-1:0]           tx_reset_datapath_out,
  output logic [NUM_CHANNELS-1:0]           rx_reset_datapath_out,
  output logic [NUM_CHANNELS-1:0]           link_up_out,
  output logic [STATE_W*NUM_CHANNELS-1:0]   link_state_out,
  output logic [CNT_W*NUM_CHANNELS-1:0]     err_count_out,
  output logic [CNT_W*NUM_CHANNELS-1:0]     resync_count_out
);

  // One fully independent controller per channel
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    hssl_link_channel_fsm #(
      .RESET_PULSE     (RESET_PULSE),
      .RESET_TIMEOUT   (RESET_TIMEOUT),
      .SYNC_GOOD_COUNT (SYNC_GOOD_COUNT),
      .ERR_WINDOW      (ERR_WINDOW),
      .ERR_THRESHOLD   (ERR_THRESHOLD)
    ) u_ch (
      .clk               (clk_in),
      .reset             (reset_in),
      .enable            (enable_in[i]),
      .tx_reset_done     (tx_reset_done_in[i]),
      .rx_reset_done     (rx_reset_done_in[i]),
      .rx_commadet       (rx_commadet_in[i]),
      .rx_error          (rx_error_in[i]),
      .tx_reset_datapath (tx_reset_datapath_out[i]),
      .rx_reset_datapath (rx_reset_datapath_out[i]),
      .link_up           (link_up_out[i]),
      .link_state        (link_state_out[STATE_W*i +: STATE_W]),
      .err_count         (err_count_out[CNT_W*i +: CNT_W]),
      .resync_count      (resync_count_out[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: doc/hssl_link_manager.md
Name: hssl_link_manager

Overview:
Per-channel bring-up and supervision controller for N HSSL gigabit transceiver channels, generalising single-link transceiver support to NUM_CHANNELS.
Per channel it sequences the TX then RX datapath resets, waits for reset-done, checks comma alignment, declares link-up, and monitors error rate.
Losing sync triggers automatic re-reset.
Sits between the transceiver wrapper(s) and top-level control/status registers.

Parameters:
NUM_CHANNELS, 1, number of independent transceiver channels
RESET_PULSE, 16, cycles a datapath reset is held asserted in *_RST states (>=1)
RESET_TIMEOUT, 65535, cycles allowed in TX_WAIT/RX_WAIT/ALIGN before retry
SYNC_GOOD_COUNT, 64, consecutive error-free commas required to declare link up
ERR_WINDOW, 1024, error-rate observation window in cycles while UP
ERR_THRESHOLD, 4, errors within one window that force resync (>=1)

Ports:
clk_in  input  1  free-running clock; all inputs are already in this domain (CDC done by caller)
reset_in  input  1  synchronous active-high reset
enable_in  input  NUM_CHANNELS  per-channel link enable
tx_reset_done_in  input  NUM_CHANNELS  transceiver TX reset done
rx_reset_done_in  input  NUM_CHANNELS  transceiver RX reset done
rx_commadet_in  input  NUM_CHANNELS  comma detected this cycle
rx_error_in  input  NUM_CHANNELS  disparity or not-in-table error this cycle (OR of byte lanes)
tx_reset_datapath_out  output  NUM_CHANNELS  TX datapath reset request
rx_reset_datapath_out  output  NUM_CHANNELS  RX datapath reset request
link_up_out  output  NUM_CHANNELS  channel in UP
link_state_out  output  3*NUM_CHANNELS  per-channel state code, channel i at [3i+2:3i]
err_count_out  output  8*NUM_CHANNELS  saturating error count while UP
resync_count_out  output  8*NUM_CHANNELS  saturating retry/resync count

Behaviour:
- Reset (reset_in=1): every channel enters IDLE. tx/rx_reset_datapath_out all 1. link_up_out 0. Counters 0.
- State codes: IDLE=0, TX_RST=1, TX_WAIT=2, RX_RST=3, RX_WAIT=4, ALIGN=5, UP=6.
- All outputs are decoded from registered state: they change in the same cycle the state changes.
- tx_reset_datapath_out=1 in IDLE and TX_RST only.
- rx_reset_datapath_out=1 in IDLE, TX_RST, TX_WAIT and RX_RST.
- link_up_out=1 in UP only.
- Transitions:
  - IDLE -> TX_RST when enable_in=1.
  - TX_RST -> TX_WAIT after exactly RESET_PULSE cycles.
  - TX_WAIT -> RX_RST when tx_reset_done_in=1. On RESET_TIMEOUT cycles elapsed -> TX_RST, resync+1.
  - RX_RST -> RX_WAIT after RESET_PULSE cycles.
  - RX_WAIT -> ALIGN when rx_reset_done_in=1. On timeout -> RX_RST, resync+1.
  - ALIGN: good counter +1 per cycle with commadet=1 and error=0. Any error clears it. Reaching SYNC_GOOD_COUNT -> UP. On timeout -> RX_RST, resync+1.
  - UP, priority order:
    1. tx_reset_done_in=0 -> TX_RST, resync+1.
    2. Else rx_reset_done_in=0 -> RX_WAIT, resync+1.
    3. Else window error count reaching ERR_THRESHOLD -> RX_RST, resync+1.
- enable_in=0 in any state -> IDLE next cycle; this overrides all other conditions. The counters retain their values.
- Timeout/pulse counter clears on every state entry.
- Error window (UP only): window counter restarts on UP entry and wraps at ERR_WINDOW-1. Window error count clears at wrap. If an error arrives on the wrap cycle, the new window count = 1.
- err_count_out increments on each rx_error_in=1 cycle in UP. It and resync_count_out saturate at 255 and clear only on reset_in.
- Channels are fully independent; no shared state.

Optional Feature:
HSSL_LINK_STATS_EN
- Defined: err_count_out and resync_count_out implemented as described.
- Undefined: counter registers omitted, both outputs tied to 0; state machine behaviour is identical.

Decomposition:
- Package hssl_link_pkg holds:
  - state encoding constants (IDLE..UP, 3-bit);
  - STATE_W=3 and CNT_W=8.
- One sub-module, hssl_link_channel_fsm: single-channel FSM plus its counters, instantiated NUM_CHANNELS times in a generate loop.
- The top level only slices buses.

Test Plan:
- NUM_CHANNELS=2, RESET_PULSE=4, SYNC_GOOD_COUNT=8; after reset set enable=2'b01, tx/rx_done rise 3 cycles after their resets drop, commadet every cycle, no errors.
  -> ch0 tx_reset held 4 cycles, then rx_reset held; link_up_out[0]=1 exactly 8 cycles after entering ALIGN. ch1 stays IDLE (state 0, both resets 1).
- RESET_TIMEOUT=100, tx_reset_done_in held 0 -> TX_RST re-entered every 4+100 cycles; resync_count_out increments 1,2,3...
- In ALIGN, error injected at good count 7 -> counter restarts; UP reached only after 8 further clean commas.
- In UP, ERR_WINDOW=16, ERR_THRESHOLD=4: 3 errors in one window -> stays UP, err_count=3. 4 errors in one window -> RX_RST next cycle, link_up=0, resync+1.
- In UP, tx_reset_done and rx_reset_done both drop in the same cycle -> TX_RST (TX priority).
- Drop enable mid-ALIGN -> IDLE next cycle, both resets 1. Assert reset_in mid-UP -> all outputs and counters 0/reset values next cycle.
- Without HSSL_LINK_STATS_EN, rerun the error test -> counts remain 0 and state sequence is identical.
